rot_issue_stage: RTL and testbench

Request-buffering and result-capture stage wrapped around the combinational 32-bit right-rotator. Accepts rotate requests (operand, amount, direction) on a valid/ready port and queues them in a DEPTH-entry FIFO. Converts left rotates to equivalent right amounts, drives the FIFO head onto the rotator inputs, and registers the rotator output into a valid/ready result port. It sits directly upstream of the rotator, feeding it, and directly downstream of it, consuming its output.

---
 rtl/rot_issue_stage.sv | 108 ++++++++++
 tb/tb_rot_issue_stage.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rot_issue_stage.sv
// Request FIFO feeding an external combinational right-rotator, with a registered result port.
// Define ROT_LEFT_EN to honour in_dir (left rotates converted to right amounts); otherwise in_dir is ignored.
module rot_issue_stage #(
  parameter int N     = 32,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [N-1:0]           in_data,
  input  logic [4:0]             in_amt,
  input  logic                   in_dir,
  output logic [N-1:0]           rot_in,
  output logic [4:0]             rot_s,
  input  logic [N-1:0]           rot_out,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [N-1:0]           out_data,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          out_valid_q, out_valid_d;
  logic [N-1:0]  out_data_q, out_data_d;

  logic [N-1:0]  data_mem_q [DEPTH];
  logic [4:0]    amt_mem_q  [DEPTH];
  logic [DEPTH-1:0] wr_en;

  logic [4:0] amt_r;
  logic       push;
  logic       load;

`ifdef ROT_LEFT_EN
  // A left rotate by k equals a right rotate by (32 - k) mod 32.
  assign amt_r = in_dir ? (5'd0 - in_amt) : in_amt;
`else
  logic unused_dir;
  assign unused_dir = in_dir;
  assign amt_r      = in_amt;
`endif

  assign in_ready = !rst && (count_q < CW'(DEPTH));
  assign push     = in_valid && in_ready;
  assign load     = (count_q != '0) && (!out_valid_q || out_ready);

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_wr_en
    assign wr_en[gi] = push && (wr_ptr_q == PW'(gi));
  end

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q + CW'(push) - CW'(load);
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end
    if (load) begin
      rd_ptr_d    = rd_ptr_q + PW'(1);
      out_valid_d = 1'b1;
      out_data_d  = rot_out;
    end else if (out_ready && out_valid_q) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        data_mem_q[i] <= '0;
        amt_mem_q[i]  <= '0;
      end
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      for (int i = 0; i < DEPTH; i++) begin
        if (wr_en[i]) begin
          data_mem_q[i] <= in_data;
          amt_mem_q[i]  <= amt_r;
        end
      end
    end
  end

  // Head storage drives the rotator directly; contents are don't-care when empty.
  assign rot_in    = data_mem_q[rd_ptr_q];
  assign rot_s     = amt_mem_q[rd_ptr_q];
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign count     = count_q;

endmodule

// File: tb/tb_rot_issue_stage.sv
// Self-checking bench for rot_issue_stage: queue-based reference model compared every cycle,
// plus directed literal checks. Models the external rotator combinationally.
module tb_rot_issue_stage;
  localparam int N     = 32;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_dir = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] in_data = '0;
  logic [4:0]  in_amt = '0;
  logic        in_ready;
  logic        out_valid;
  logic [31:0] rot_in;
  logic [31:0] rot_out;
  logic [31:0] out_data;
  logic [4:0]  rot_s;
  logic [2:0]  count;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] d;
    int          s;
    logic [31:0] res;
  } req_t;

  req_t        mq[$];
  logic        m_valid = 1'b0;
  logic [31:0] m_data  = '0;
  bit          live    = 1'b0;

  logic [31:0] t3_exp [5] = '{32'h80000000, 32'h00000001, 32'h80000001, 32'h00000002, 32'h80000002};

  always #5 clk = ~clk;

  rot_issue_stage #(.N(N), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_amt(in_amt), .in_dir(in_dir),
    .rot_in(rot_in), .rot_s(rot_s), .rot_out(rot_out),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .count(count)
  );

  function automatic logic [31:0] rotr(input logic [31:0] x, input int s);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = x[(i + s) % 32];
    return r;
  endfunction

  function automatic logic [31:0] rotl(input logic [31:0] x, input int s);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[(i + s) % 32] = x[i];
    return r;
  endfunction

  assign rot_out = rotr(rot_in, int'(rot_s));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] d, input logic [4:0] a,
                       input logic dir, input logic ordy);
    in_valid  = v;
    in_data   = d;
    in_amt    = a;
    in_dir    = dir;
    out_ready = ordy;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: a plain queue of accepted requests plus the held result.
  initial begin
    bit   acc;
    bit   ld;
    req_t r;
    forever begin
      @(posedge clk);
      if (rst) begin
        mq.delete();
        m_valid = 1'b0;
        m_data  = '0;
        live    = 1'b1;
      end else begin
        acc = in_valid && (mq.size() < DEPTH);
        ld  = (mq.size() > 0) && (!m_valid || out_ready);
        if (ld) begin
          m_data  = mq[0].res;
          m_valid = 1'b1;
          void'(mq.pop_front());
        end else if (out_ready && m_valid) begin
          m_valid = 1'b0;
        end
        if (acc) begin
          r.d = in_data;
`ifdef ROT_LEFT_EN
          if (in_dir) begin
            r.s   = (32 - int'(in_amt)) % 32;
            r.res = rotl(in_data, int'(in_amt));
          end else begin
            r.s   = int'(in_amt);
            r.res = rotr(in_data, int'(in_amt));
          end
`else
          r.s   = int'(in_amt);
          r.res = rotr(in_data, int'(in_amt));
`endif
          mq.push_back(r);
        end
      end
    end
  end

  // Per-cycle comparison against the model, plus hold-while-stalled check.
  initial begin
    bit          prev_stall;
    logic [31:0] prev_data;
    int          nres;
    prev_stall = 1'b0;
    prev_data  = '0;
    nres       = 0;
    forever begin
      @(negedge clk);
      if (live) begin
        chk("in_ready", 32'(in_ready), 32'(!rst && (mq.size() < DEPTH)));
        chk("count", 32'(count), 32'(mq.size()));
        chk("out_valid", 32'(out_valid), 32'(m_valid));
        chk("out_data", out_data, m_data);
        if (mq.size() > 0) begin
          chk("rot_in", rot_in, mq[0].d);
          chk("rot_s", 32'(rot_s), 32'(mq[0].s));
        end
        if (prev_stall) begin
          chk("hold_valid", 32'(out_valid), 32'd1);
          chk("hold_data", out_data, prev_data);
        end
        prev_stall = out_valid && !out_ready && !rst;
        prev_data  = out_data;
        if (out_valid && out_ready && !rst) begin
          $display("result %0d: data=%h", nres, out_data);
          nres++;
        end
      end
    end
  end

  initial begin
    int acc;
    int cyc;
    bit v;

    // Reset state
    rst = 1'b1;
    repeat (2) tick();
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_rot_in", rot_in, 32'd0);
    chk("rst_rot_s", 32'(rot_s), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    rst = 1'b0;
    #1;
    chk("rel_in_ready", 32'(in_ready), 32'd1);

    // Basic right rotate, 2-cycle latency
    drive(1'b1, 32'h12345678, 5'd4, 1'b0, 1'b1);
    tick();
    drive(1'b0, 32'h0, 5'd0, 1'b0, 1'b1);
    chk("t1_count", 32'(count), 32'd1);
    chk("t1_rot_s", 32'(rot_s), 32'd4);
    chk("t1_ov_early", 32'(out_valid), 32'd0);
    tick();
    chk("t1_ov", 32'(out_valid), 32'd1);
    chk("t1_data", out_data, 32'h81234567);
    chk("t1_count_end", 32'(count), 32'd0);
    tick();

    // Direction handling
    drive(1'b1, 32'h12345678, 5'd4, 1'b1, 1'b1);
    tick();
    drive(1'b0, 32'h0, 5'd0, 1'b0, 1'b1);
`ifdef ROT_LEFT_EN
    chk("t2_rot_s", 32'(rot_s), 32'd28);
    tick();
    chk("t2_data", out_data, 32'h23456781);
`else
    chk("t2_rot_s", 32'(rot_s), 32'd4);
    tick();
    chk("t2_data", out_data, 32'h81234567);
`endif
    drive(1'b1, 32'hCAFEF00D, 5'd0, 1'b1, 1'b1);
    tick();
    drive(1'b0, 32'h0, 5'd0, 1'b0, 1'b1);
    chk("t2_rot_s0", 32'(rot_s), 32'd0);
    tick();
    chk("t2_data0", out_data, 32'hCAFEF00D);
    tick();

    // Fill with back-pressure, then drain in order
    for (int k = 1; k <= 5; k++) begin
      drive(1'b1, 32'(k), 5'd1, 1'b0, 1'b0);
      tick();
    end
    chk("t3_count", 32'(count), 32'd4);
    chk("t3_ov", 32'(out_valid), 32'd1);
    chk("t3_in_ready", 32'(in_ready), 32'd0);
    drive(1'b1, 32'd6, 5'd1, 1'b0, 1'b0);
    tick();
    chk("t3_full_hold", 32'(count), 32'd4);
    drive(1'b0, 32'h0, 5'd0, 1'b0, 1'b1);
    for (int j = 0; j < 5; j++) begin
      chk("t3_drain_ov", 32'(out_valid), 32'd1);
      chk("t3_drain_data", out_data, t3_exp[j]);
      tick();
    end
    chk("t3_empty_ov", 32'(out_valid), 32'd0);

    // Full, then sustained push/pop across pointer wrap
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, 32'h100 + 32'(k), 5'd3, 1'b0, 1'b0);
      tick();
    end
    chk("t4_in_ready", 32'(in_ready), 32'd0);
    chk("t4_count", 32'(count), 32'd4);
    for (int k = 0; k < 12; k++) begin
      drive(1'b1, 32'h200 + 32'(k), 5'd7, k[0], 1'b1);
      tick();
      if (k == 0) chk("t4_pop_only", 32'(count), 32'd3);
    end
    chk("t4_steady", 32'(count), 32'd3);
    drive(1'b0, 32'h0, 5'd0, 1'b0, 1'b1);
    repeat (6) tick();
    chk("t4_drained_ov", 32'(out_valid), 32'd0);
    chk("t4_drained_cnt", 32'(count), 32'd0);

    // Random traffic with random back-pressure
    acc = 0;
    cyc = 0;
    while (acc < 1000 && cyc < 20000) begin
      v = ($urandom_range(0, 3) != 0);
      drive(v, $urandom, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)));
      if (v && in_ready) acc++;
      tick();
      cyc++;
    end
    chk("t5_accepted", 32'(acc), 32'd1000);
    drive(1'b0, 32'h0, 5'd0, 1'b0, 1'b1);
    repeat (8) tick();
    chk("t5_drained_cnt", 32'(count), 32'd0);
    chk("t5_drained_ov", 32'(out_valid), 32'd0);

    // Reset mid-operation
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 32'h300 + 32'(k), 5'd2, 1'b0, 1'b0);
      tick();
    end
    chk("t6_count", 32'(count), 32'd3);
    chk("t6_ov", 32'(out_valid), 32'd1);
    rst = 1'b1;
    drive(1'b0, 32'h0, 5'd0, 1'b0, 1'b0);
    tick();
    chk("t6_rst_count", 32'(count), 32'd0);
    chk("t6_rst_ov", 32'(out_valid), 32'd0);
    chk("t6_rst_data", out_data, 32'd0);
    chk("t6_rst_ready", 32'(in_ready), 32'd0);
    rst = 1'b0;
    drive(1'b1, 32'hA5A50F0F, 5'd8, 1'b0, 1'b1);
    tick();
    drive(1'b0, 32'h0, 5'd0, 1'b0, 1'b1);
    tick();
    chk("t6_post_ov", 32'(out_valid), 32'd1);
    chk("t6_post_data", out_data, 32'h0FA5A50F);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
